demux_base: RTL and testbench
=============================

Name: demux_base

Overview:
- Registered 1-to-NUMBER_INPUT demultiplexer: the inverse of the team's N-to-1 MUX block.
- Takes one BIT-wide word with a lane select and a valid/ready handshake. Steers the word into a per-lane FIFO of depth LANE_DEPTH.
- Each lane presents its head word on its own slice of the packed output bus, with an independent valid/ready handshake.
- Sits between a single serial producer and NUMBER_INPUT independent consumers; also serves as the stimulus fan-out for MUX round-trip benches.

Parameters:
- BIT, 19, data word width.
- NUMBER_INPUT, 8, number of output lanes; need not be a power of two.
- LANE_DEPTH, 2, entries per lane FIFO; must be >= 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word this cycle.
- in_ready  output  1  block accepts the word this cycle (combinational).
- sel  input  $clog2(NUMBER_INPUT)  destination lane index.
- IN  input  BIT  data word.
- out_valid  output  NUMBER_INPUT  bit k: lane k head word is valid.
- out_ready  input  NUMBER_INPUT  bit k: consumer k takes its head word.
- OUT  output  NUMBER_INPUT*BIT  lane k head word at OUT[k*BIT +: BIT].
- sel_err  output  1  registered one-cycle pulse: a word with an out-of-range sel was dropped.

Behaviour:
- Reset (async assert, sync release): all lane counts and pointers = 0, out_valid = 0, OUT = 0, sel_err = 0.
- Lane k pop: occurs when out_valid[k] && out_ready[k] at a rising edge.
- Lane k empty: OUT slice k is driven 0 (not stale data), out_valid[k] = 0.
- sel_ok = (sel < NUMBER_INPUT).
- in_ready:
  - If sel_ok: in_ready = (cnt[sel] < LANE_DEPTH) || (out_valid[sel] && out_ready[sel]).
  - If !sel_ok: in_ready = 1.
  - in_ready is a function of the current sel, so it is meaningful only while in_valid = 1.
- Accept = in_valid && in_ready.
  - sel_ok: write IN at the tail of lane sel.
  - !sel_ok: drop the word; sel_err = 1 on the next cycle only.
- Latency: a word accepted at edge N into an empty lane shows on out_valid/OUT immediately after edge N, i.e. one cycle. There is no combinational IN-to-OUT path.
- Ordering: words to the same lane exit in acceptance order. There is no ordering relation across lanes.
- Simultaneous push and pop on the same lane:
  - The count is unchanged; the head advances and the new word is appended.
  - When the lane is full this is allowed, because in_ready includes the pop term.
  - When the lane is empty a push and a pop cannot coincide, since out_valid = 0.
- Pops on different lanes are fully independent; any subset of lanes may pop in one cycle.
- Pointer wrap: read/write pointers wrap modulo LANE_DEPTH. The count ranges 0..LANE_DEPTH and never exceeds it.
- Holding rule: out_valid[k] and OUT slice k stay stable while out_valid[k] = 1 and out_ready[k] = 0.
- in_valid = 0: IN and sel are don't-care (X-tolerant). No state changes from the input side; sel_err is not asserted.
- Reset mid-operation: all buffered words are discarded and outputs return to their reset values asynchronously. No partial word survives.

Test Plan:
- Reset check: hold rst_n = 0 for 5 cycles with IN/sel = X -> out_valid = 0, OUT = 0, sel_err = 0 throughout; in_ready = 1 after release with in_valid = 1, sel = 0.
- Single route with out_ready = all 1: IN = 19'h5A5A5, sel = 3, in_valid for 1 cycle -> next cycle out_valid = 8'b0000_1000 and OUT[3*19 +: 19] = 19'h5A5A5; the following cycle out_valid = 0.
- Full lane with LANE_DEPTH = 2, out_ready = 0:
  - Push 19'h00001, 19'h00002 to lane 5 -> in_ready = 0 for sel = 5, but in_ready = 1 for sel = 2.
  - Then raise out_ready[5] and push 19'h00003 in the same cycle -> accepted; lane 5 then emits 2 followed by 3.
- Out-of-range select with NUMBER_INPUT = 6: sel = 7, in_valid = 1 -> in_ready = 1, no out_valid change, sel_err = 1 for exactly one cycle.
- Random stress, 100 patterns: random sel in 0..7, random IN, random out_ready -> per-lane scoreboard confirms order and data, no loss or duplication, and OUT stable while stalled.
- Mid-burst reset: 3 words buffered across lanes 0/1, assert rst_n = 0 asynchronously between edges -> out_valid = 0 and OUT = 0 immediately; after release, lanes are empty.

Source files
------------

// File: rtl/demux_base_if.sv
// Producer/consumer bundle for demux_base: one input port with a lane select and
// NUMBER_INPUT output lanes, each with its own valid/ready pair.
interface demux_base_if #(
    parameter int BIT          = 19,
    parameter int NUMBER_INPUT = 8
);
    localparam int SEL_W = (NUMBER_INPUT > 1) ? $clog2(NUMBER_INPUT) : 1;

    // Valid/ready: a word moves on a rising edge where valid and ready are both 1.
    // A source holds valid and its data stable until that edge; ready may toggle freely.
    logic                        in_valid;
    logic                        in_ready;
    logic [SEL_W-1:0]            sel;
    logic [BIT-1:0]              IN;
    logic [NUMBER_INPUT-1:0]     out_valid;
    logic [NUMBER_INPUT-1:0]     out_ready;
    logic [NUMBER_INPUT*BIT-1:0] OUT;
    logic                        sel_err;

    modport master (
        output in_valid, sel, IN, out_ready,
        input  in_ready, out_valid, OUT, sel_err
    );

    modport slave (
        input  in_valid, sel, IN, out_ready,
        output in_ready, out_valid, OUT, sel_err
    );
endinterface

// File: rtl/demux_base.sv
// Registered 1-to-NUMBER_INPUT demultiplexer: each accepted word is appended to the
// FIFO of the selected lane; each lane drains through its own valid/ready handshake.
module demux_base #(
    parameter int BIT          = 19,
    parameter int NUMBER_INPUT = 8,
    parameter int LANE_DEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    demux_base_if.slave  bus
);
    localparam int SEL_W = (NUMBER_INPUT > 1) ? $clog2(NUMBER_INPUT) : 1;
    localparam int PTR_W = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
    localparam int CNT_W = $clog2(LANE_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANE_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANE_DEPTH);
    localparam logic [SEL_W:0]   LANES    = (SEL_W + 1)'(NUMBER_INPUT);

    logic                        sel_ok;
    logic                        accept;
    logic                        sel_err_q;
    logic [NUMBER_INPUT-1:0]     lane_hit;
    logic [NUMBER_INPUT-1:0]     lane_room;
    logic [NUMBER_INPUT-1:0]     lane_push;
    logic [NUMBER_INPUT-1:0]     lane_pop;
    logic [NUMBER_INPUT-1:0]     lane_valid;
    logic [NUMBER_INPUT*BIT-1:0] lane_data;

    // NUMBER_INPUT need not be a power of two, so some sel codes address no lane.
    assign sel_ok = {1'b0, bus.sel} < LANES;

    always_comb begin
        lane_hit = '0;
        for (int k = 0; k < NUMBER_INPUT; k++) begin
            lane_hit[k] = sel_ok && (bus.sel == SEL_W'(k));
        end
    end

    // Out-of-range words are always taken so the producer never stalls on them.
    assign bus.in_ready = !sel_ok || (|(lane_hit & lane_room));
    assign accept       = bus.in_valid && bus.in_ready;
    assign lane_push    = {NUMBER_INPUT{accept}} & lane_hit;
    assign lane_pop     = lane_valid & bus.out_ready;

    for (genvar k = 0; k < NUMBER_INPUT; k++) begin : g_lane
        logic [BIT-1:0]   mem [LANE_DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (lane_push[k]) begin
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                end
                if (lane_pop[k]) begin
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                end
                case ({lane_push[k], lane_pop[k]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage needs no reset: the count gates everything that reaches the outputs.
        always_ff @(posedge clk) begin
            if (lane_push[k]) begin
                mem[wr_ptr] <= bus.IN;
            end
        end

        // A full lane still accepts when its head leaves on the same edge.
        assign lane_room[k]               = (cnt < CNT_FULL) || lane_pop[k];
        assign lane_valid[k]              = (cnt != '0);
        assign lane_data[k*BIT +: BIT]    = lane_valid[k] ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= accept && !sel_ok;
        end
    end

    assign bus.out_valid = lane_valid;
    assign bus.OUT       = lane_data;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_demux_base.sv
// Bench for demux_base: an 8-lane instance under directed and random traffic against a
// per-lane queue model, plus a 6-lane instance for out-of-range selects.
module tb_demux_base;
    localparam int BIT   = 19;
    localparam int NL    = 8;
    localparam int NL6   = 6;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux_base_if #(.BIT(BIT), .NUMBER_INPUT(NL))  bus ();
    demux_base_if #(.BIT(BIT), .NUMBER_INPUT(NL6)) bus6 ();

    demux_base #(.BIT(BIT), .NUMBER_INPUT(NL), .LANE_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    demux_base #(.BIT(BIT), .NUMBER_INPUT(NL6), .LANE_DEPTH(DEPTH)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [BIT-1:0] exp_q [NL][$];
    logic           err_pending = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BIT-1:0] slice_of(input logic [NL*BIT-1:0] v, input int k);
        return v[k*BIT +: BIT];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver side of the scoreboard: every accepted in-range word joins its lane's queue.
    always @(negedge clk) begin
        logic [BIT-1:0] d;
        int             s;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            d = bus.IN;
            s = int'(bus.sel);
            #1;
            if (rst_n && s < NL) exp_q[s].push_back(d);
        end
    end

    // Monitor: model state before the coming edge predicts every output of the 8-lane DUT.
    always @(negedge clk) begin
        logic           exp_rdy;
        logic           exp_v;
        logic [BIT-1:0] exp_d;
        int             s;
        if (!rst_n) begin
            for (int k = 0; k < NL; k++) exp_q[k].delete();
            err_pending = 1'b0;
            check("mon_rst_valid", bus.out_valid, '0);
            check("mon_rst_out", bus.OUT, '0);
            check("mon_rst_sel_err", bus.sel_err, '0);
        end else begin
            check("mon_sel_err", bus.sel_err, err_pending);
            err_pending = 1'b0;
            if (bus.in_valid) begin
                s = int'(bus.sel);
                if (s < NL) begin
                    exp_rdy = (exp_q[s].size() < DEPTH) || (exp_q[s].size() > 0 && bus.out_ready[s]);
                end else begin
                    exp_rdy     = 1'b1;
                    err_pending = 1'b1;
                end
                check("mon_in_ready", bus.in_ready, exp_rdy);
            end
            for (int k = 0; k < NL; k++) begin
                exp_v = (exp_q[k].size() != 0);
                exp_d = exp_v ? exp_q[k][0] : '0;
                check($sformatf("mon_lane%0d_valid", k), bus.out_valid[k], exp_v);
                check($sformatf("mon_lane%0d_data", k), slice_of(bus.OUT, k), exp_d);
                if (exp_v && bus.out_ready[k]) void'(exp_q[k].pop_front());
            end
        end
    end

    initial begin
        logic [BIT-1:0] d6;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.sel        = 'x;
        bus.IN         = 'x;
        bus.out_ready  = '1;
        bus6.in_valid  = 1'b0;
        bus6.sel       = '0;
        bus6.IN        = '0;
        bus6.out_ready = '1;

        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("reset_valid", bus.out_valid, '0);
            check("reset_out", bus.OUT, '0);
            check("reset_sel_err", bus.sel_err, '0);
        end

        next_cycle();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 3'd0;
        bus.IN       = BIT'($urandom);
        #1 check("ready_after_reset", bus.in_ready, 1'b1);
        next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();

        // Single route to lane 3 with every consumer ready.
        next_cycle();
        bus.in_valid = 1'b1;
        bus.sel      = 3'd3;
        bus.IN       = 19'h5A5A5;
        next_cycle();
        bus.in_valid = 1'b0;
        check("route_valid", bus.out_valid, 8'b0000_1000);
        check("route_data", slice_of(bus.OUT, 3), 19'h5A5A5);
        next_cycle();
        check("route_gone", bus.out_valid, '0);

        // Fill lane 5, then push into it on the same edge that pops its head.
        bus.out_ready = '0;
        bus.in_valid  = 1'b1;
        bus.sel       = 3'd5;
        bus.IN        = 19'h00001;
        next_cycle();
        bus.IN        = 19'h00002;
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.sel       = 3'd5;
        #1 check("full_ready_lane5", bus.in_ready, 1'b0);
        bus.sel       = 3'd2;
        #1 check("free_ready_lane2", bus.in_ready, 1'b1);
        next_cycle();
        bus.out_ready = 8'b0010_0000;
        bus.in_valid  = 1'b1;
        bus.sel       = 3'd5;
        bus.IN        = 19'h00003;
        #1 check("full_push_pop_ready", bus.in_ready, 1'b1);
        next_cycle();
        bus.in_valid = 1'b0;
        check("lane5_first", slice_of(bus.OUT, 5), 19'h00002);
        next_cycle();
        check("lane5_second", slice_of(bus.OUT, 5), 19'h00003);
        next_cycle();
        check("lane5_drained", bus.out_valid, '0);
        bus.out_ready = '1;

        // Out-of-range select on the 6-lane instance.
        check("oor_err_idle", bus6.sel_err, 1'b0);
        bus6.in_valid = 1'b1;
        bus6.sel      = 3'd7;
        bus6.IN       = BIT'($urandom);
        #1 check("oor_ready", bus6.in_ready, 1'b1);
        next_cycle();
        bus6.in_valid = 1'b0;
        check("oor_err_pulse", bus6.sel_err, 1'b1);
        check("oor_no_valid", bus6.out_valid, '0);
        next_cycle();
        check("oor_err_cleared", bus6.sel_err, 1'b0);
        check("oor_no_valid2", bus6.out_valid, '0);
        d6            = BIT'($urandom);
        bus6.in_valid = 1'b1;
        bus6.sel      = 3'd2;
        bus6.IN       = d6;
        next_cycle();
        bus6.in_valid = 1'b0;
        check("six_route_valid", bus6.out_valid, 6'b00_0100);
        check("six_route_data", bus6.OUT[2*BIT +: BIT], d6);

        // Random traffic; the monitor checks order, data, stalls and back-pressure.
        for (int i = 0; i < 100; i++) begin
            next_cycle();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.sel       = 3'($urandom_range(0, 7));
            bus.IN        = BIT'($urandom);
            bus.out_ready = NL'($urandom);
        end
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = '1;
        for (int i = 0; i < 4; i++) next_cycle();
        check("random_drained", bus.out_valid, '0);

        // Buffer three words, then reset between edges.
        bus.out_ready = '0;
        bus.in_valid  = 1'b1;
        bus.sel       = 3'd0;
        bus.IN        = 19'h11111;
        next_cycle();
        bus.sel       = 3'd1;
        bus.IN        = 19'h22222;
        next_cycle();
        bus.sel       = 3'd0;
        bus.IN        = 19'h33333;
        next_cycle();
        bus.in_valid  = 1'b0;
        check("burst_buffered", bus.out_valid, 8'b0000_0011);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, '0);
        check("async_rst_out", bus.OUT, '0);
        next_cycle();
        next_cycle();
        rst_n         = 1'b1;
        bus.out_ready = '1;
        next_cycle();
        check("post_rst_empty", bus.out_valid, '0);
        next_cycle();
        check("post_rst_out", bus.OUT, '0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
